ctrl_fsm: RTL and testbench
===========================

# ctrl_fsm

Parametrised successor to the two-phase CPU controller. Sequences fetch and execute for the 8-bit datapath, with a memory-ready handshake on fetch and a sticky HALT state released by a `resume` pulse. It also flags illegal opcodes and registers every datapath control output. It sits between the instruction register and the PC, register file, accumulator and ALU select lines.

## Interface
Parameters:
- `OPW`, default 4: opcode width; opcode values ≥ 16 are illegal.
- `ALUW`, default 4: SelALU width; the low 4 bits carry the codes below, upper bits are 0.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `CL`, input, 1: reset, asynchronous, active-high.
- `opcode`, input, OPW: IR contents, valid from the cycle after LoadIR.
- `Z`, input, 1: ALU zero flag.
- `C`, input, 1: ALU carry flag.
- `mem_ready`, input, 1: instruction memory data valid this cycle.
- `resume`, input, 1: single-cycle pulse that leaves HALT.
- `LoadIR`, output, 1: load instruction register.
- `IncPC`, output, 1: increment PC.
- `SelPC`, output, 1: PC source; 1 = REG, 0 = IMM.
- `LoadPC`, output, 1: load PC.
- `LoadReg`, output, 1: load register from ACC.
- `LoadAcc`, output, 1: load accumulator.
- `SelAcc`, output, 2: accumulator source; 00 = ALU, 10 = REG, 11 = IMM.
- `SelALU`, output, ALUW: ALU function.
- `halted`, output, 1: controller is in HALT.
- `illegal`, output, 1: sticky flag, set by an illegal opcode.

## Operation
- States: RESET, FETCH, EXEC, HALT.
- RESET → FETCH on the first clock after `CL` deasserts.
- FETCH: `LoadIR`=1, all other strobes 0. Stay in FETCH while `mem_ready`=0. On `mem_ready`=1, go to EXEC.
- EXEC decodes `opcode`, drives its strobes for exactly one cycle, then returns to FETCH. Exceptions: opcode 15 and illegal opcodes go to HALT.
- Decode in EXEC (strobes not listed are 0):
  - 0 NOP: IncPC.
  - 1 ADD: IncPC, LoadAcc, SelALU=1000.
  - 2 SUB: IncPC, LoadAcc, SelALU=1100.
  - 3 NOR: IncPC, LoadAcc, SelALU=0100.
  - 4 ACC←REG: IncPC, LoadAcc, SelAcc=10.
  - 5 REG←ACC: IncPC, LoadReg, SelALU=0010.
  - 6 JZ REG and 7 JZ IMM: LoadPC=Z, IncPC=~Z. SelPC=1 for opcode 6, 0 for opcode 7.
  - 8 JC REG and 10 JC IMM: LoadPC=C, IncPC=~C. SelPC=1 for opcode 8, 0 for opcode 10.
  - 9 JNZ IMM: LoadPC=~Z, IncPC=Z, SelPC=0.
  - 11 SHL: IncPC, LoadAcc, SelALU=0001.
  - 12 SHR: IncPC, LoadAcc, SelALU=0011.
  - 13 LDI: IncPC, LoadAcc, SelAcc=11.
  - 14 and ≥16 (illegal): no strobes; set `illegal`; go to HALT.
  - 15 STOP: no strobes; go to HALT.
- HALT: all strobes 0, `halted`=1.
  - `resume`=1 → FETCH. PC is not incremented, so a STOP is re-fetched unless software has patched memory.
  - `resume` is ignored outside HALT.
- `illegal` clears only on reset.
- LoadPC and IncPC are never both 1.

## Timing
- All outputs are registered. Strobes for an EXEC cycle are computed from `opcode`, Z and C sampled at the FETCH→EXEC edge, and are valid for that EXEC cycle.
- Minimum instruction time is 2 cycles (FETCH with `mem_ready`=1, then EXEC). Each `mem_ready`=0 cycle adds one.
- Reset values: every strobe 0, SelAcc=00, SelALU=0, `halted`=0, `illegal`=0, state RESET.
- `CL` mid-operation forces the reset values asynchronously, including during EXEC strobes; no partial instruction completes.
- `resume` and `CL` together: `CL` wins.
- Z or C changing during EXEC has no effect.
- A `mem_ready` glitch outside FETCH is ignored.

## Structure
- Shared package `ctrl_pkg`:
  - state enum;
  - opcode localparams (OP_NOP … OP_STOP);
  - SelALU codes (ALU_ADD=1000, ALU_SUB=1100, ALU_NOR=0100, ALU_PASS=0010, ALU_SHL=0001, ALU_SHR=0011);
  - SelAcc codes.
- One sub-module, `ctrl_decode`: purely combinational opcode + flags → strobe vector plus illegal/stop bits. `ctrl_fsm` holds the state register and the output registers.

## Test plan
- Reset, then `mem_ready`=1 held, opcode 1: LoadIR cycle, then an EXEC cycle with IncPC=1, LoadAcc=1, SelALU=1000. Repeats every 2 cycles.
- `mem_ready` low for 3 cycles during FETCH: LoadIR stays 1 for 4 cycles, EXEC follows. No strobe fires early.
- Opcode 6 with Z=1: LoadPC=1, SelPC=1, IncPC=0. With Z=0: IncPC=1, LoadPC=0. Opcode 9 with Z=0: LoadPC=1, SelPC=0.
- Opcode 15: `halted`=1 and all strobes 0 for 10 cycles. `resume` pulse → FETCH on the next cycle and `halted`=0.
- Opcode 14: `illegal`=1 and `halted`=1. After `resume`, `illegal` stays 1 until `CL`.
- Assert `CL` during EXEC of opcode 13: LoadAcc drops to 0 within the same cycle with no clock edge. After release, the next state is RESET then FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the two-phase CPU controller: FSM state
// encoding, opcode values, ALU function codes, accumulator source codes and
// the packed strobe bundle that the decoder produces and the FSM registers.
// -----------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Opcode values. Anything at or above 16 is illegal, as is OP_ILL.
  localparam int unsigned OP_NOP     = 0;
  localparam int unsigned OP_ADD     = 1;
  localparam int unsigned OP_SUB     = 2;
  localparam int unsigned OP_NOR     = 3;
  localparam int unsigned OP_ACC_REG = 4;
  localparam int unsigned OP_REG_ACC = 5;
  localparam int unsigned OP_JZ_REG  = 6;
  localparam int unsigned OP_JZ_IMM  = 7;
  localparam int unsigned OP_JC_REG  = 8;
  localparam int unsigned OP_JNZ_IMM = 9;
  localparam int unsigned OP_JC_IMM  = 10;
  localparam int unsigned OP_SHL     = 11;
  localparam int unsigned OP_SHR     = 12;
  localparam int unsigned OP_LDI     = 13;
  localparam int unsigned OP_ILL     = 14;
  localparam int unsigned OP_STOP    = 15;

  // ALU function codes carried in the low four bits of SelALU.
  typedef logic [3:0] alu_code_t;
  localparam alu_code_t ALU_ADD  = 4'b1000;
  localparam alu_code_t ALU_SUB  = 4'b1100;
  localparam alu_code_t ALU_NOR  = 4'b0100;
  localparam alu_code_t ALU_PASS = 4'b0010;
  localparam alu_code_t ALU_SHL  = 4'b0001;
  localparam alu_code_t ALU_SHR  = 4'b0011;

  // Accumulator input mux select.
  typedef enum logic [1:0] {
    ACC_ALU = 2'b00,
    ACC_REG = 2'b10,
    ACC_IMM = 2'b11
  } acc_sel_t;

  // PC load source select.
  localparam logic PC_FROM_REG = 1'b1;
  localparam logic PC_FROM_IMM = 1'b0;

  // Every datapath control output in one bundle, so the FSM can register
  // the whole set with a single assignment.
  typedef struct packed {
    logic      load_ir;
    logic      inc_pc;
    logic      sel_pc;
    logic      load_pc;
    logic      load_reg;
    logic      load_acc;
    acc_sel_t  sel_acc;
    alu_code_t sel_alu;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '0;

  // Strobe set for a FETCH cycle: only the instruction register loads.
  function automatic strobes_t fetch_strobes();
    strobes_t s;
    s         = STROBES_IDLE;
    s.load_ir = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// ctrl_fsm_if
// Bundle of signals between the controller and the datapath/instruction
// memory side.
//   Datapath -> controller : opcode, Z, C, mem_ready, resume
//   Controller -> datapath : LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
//                            SelAcc, SelALU, halted, illegal
// Modports: master = controller, slave = datapath.
// -----------------------------------------------------------------------------
interface ctrl_fsm_if #(
  parameter int OPW  = 4,
  parameter int ALUW = 4
);

  logic [OPW-1:0]  opcode;
  logic            Z;
  logic            C;
  logic            mem_ready;
  logic            resume;

  logic            LoadIR;
  logic            IncPC;
  logic            SelPC;
  logic            LoadPC;
  logic            LoadReg;
  logic            LoadAcc;
  logic [1:0]      SelAcc;
  logic [ALUW-1:0] SelALU;
  logic            halted;
  logic            illegal;

  modport master (
    input  opcode, Z, C, mem_ready, resume,
    output LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
           SelAcc, SelALU, halted, illegal
  );

  modport slave (
    output opcode, Z, C, mem_ready, resume,
    input  LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
           SelAcc, SelALU, halted, illegal
  );

endinterface

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Purely combinational instruction decoder: maps an opcode plus the ALU
// flags to the strobe set for one EXEC cycle, and flags opcodes that stop
// the machine (STOP) or are illegal (14 and anything >= 16).
// Ports:
//   opcode  : instruction register contents
//   z, c    : ALU zero / carry flags
//   strobes : datapath strobes for the EXEC cycle (load_ir always 0)
//   illegal : opcode is illegal
//   stop    : opcode is STOP
// -----------------------------------------------------------------------------
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  input  logic           z,
  input  logic           c,
  output strobes_t       strobes,
  output logic           illegal,
  output logic           stop
);

  // Widening to 32 bits lets one case statement cover every OPW: values
  // >= 16 simply fall into the default branch.
  logic [31:0] op_ext;
  assign op_ext = 32'(opcode);

  // NOTE: every output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    strobes = STROBES_IDLE;
    illegal = 1'b0;
    stop    = 1'b0;

    case (op_ext)
      OP_NOP: begin
        strobes.inc_pc = 1'b1;
      end
      OP_ADD: begin
        strobes.inc_pc   = 1'b1;
        strobes.load_acc = 1'b1;
        strobes.sel_alu  = ALU_ADD;
      end
      OP_SUB: begin
        strobes.inc_pc   = 1'b1;
        strobes.load_acc = 1'b1;
        strobes.sel_alu  = ALU_SUB;
      end
      OP_NOR: begin
        strobes.inc_pc   = 1'b1;
        strobes.load_acc = 1'b1;
        strobes.sel_alu  = ALU_NOR;
      end
      OP_ACC_REG: begin
        strobes.inc_pc   = 1'b1;
        strobes.load_acc = 1'b1;
        strobes.sel_acc  = ACC_REG;
      end
      OP_REG_ACC: begin
        strobes.inc_pc   = 1'b1;
        strobes.load_reg = 1'b1;
        strobes.sel_alu  = ALU_PASS;
      end
      // Conditional branches: exactly one of load_pc / inc_pc is set, so the
      // PC never sees both a load and an increment.
      OP_JZ_REG: begin
        strobes.load_pc = z;
        strobes.inc_pc  = ~z;
        strobes.sel_pc  = PC_FROM_REG;
      end
      OP_JZ_IMM: begin
        strobes.load_pc = z;
        strobes.inc_pc  = ~z;
        strobes.sel_pc  = PC_FROM_IMM;
      end
      OP_JC_REG: begin
        strobes.load_pc = c;
        strobes.inc_pc  = ~c;
        strobes.sel_pc  = PC_FROM_REG;
      end
      OP_JNZ_IMM: begin
        strobes.load_pc = ~z;
        strobes.inc_pc  = z;
        strobes.sel_pc  = PC_FROM_IMM;
      end
      OP_JC_IMM: begin
        strobes.load_pc = c;
        strobes.inc_pc  = ~c;
        strobes.sel_pc  = PC_FROM_IMM;
      end
      OP_SHL: begin
        strobes.inc_pc   = 1'b1;
        strobes.load_acc = 1'b1;
        strobes.sel_alu  = ALU_SHL;
      end
      OP_SHR: begin
        strobes.inc_pc   = 1'b1;
        strobes.load_acc = 1'b1;
        strobes.sel_alu  = ALU_SHR;
      end
      OP_LDI: begin
        strobes.inc_pc   = 1'b1;
        strobes.load_acc = 1'b1;
        strobes.sel_acc  = ACC_IMM;
      end
      OP_STOP: begin
        stop = 1'b1;
      end
      OP_ILL: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// -----------------------------------------------------------------------------
// ctrl_fsm
// Fetch/execute sequencer for the 8-bit datapath. Waits in FETCH until the
// instruction memory reports ready, executes the decoded instruction for one
// cycle, and parks in HALT after STOP or an illegal opcode until a resume
// pulse arrives. Every control output comes straight from a flop.
// Ports:
//   clk : system clock, rising edge
//   CL  : asynchronous active-high reset
//   bus : ctrl_fsm_if.master (opcode/flags/handshake in, strobes/status out)
// Parameters:
//   OPW  : opcode width (must match bus)
//   ALUW : SelALU width (must match bus, >= 4); upper bits read as zero
// -----------------------------------------------------------------------------
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int ALUW = 4
) (
  input  logic        clk,
  input  logic        CL,
  ctrl_fsm_if.master  bus
);

  state_t   state, state_d;
  strobes_t out_q, out_d;
  logic     halted_q, halted_d;
  logic     illegal_q, illegal_d;
  // Remembers, across the EXEC cycle, that the executing instruction ends in
  // HALT. The opcode input is not re-read in EXEC, so IR changes there are
  // harmless.
  logic     stop_q, stop_d;

  strobes_t dec_strobes;
  logic     dec_illegal;
  logic     dec_stop;

  ctrl_decode #(
    .OPW (OPW)
  ) u_decode (
    .opcode  (bus.opcode),
    .z       (bus.Z),
    .c       (bus.C),
    .strobes (dec_strobes),
    .illegal (dec_illegal),
    .stop    (dec_stop)
  );

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered, so the registered copies line up with that state's cycle.
  always_comb begin
    state_d   = state;
    out_d     = STROBES_IDLE;
    illegal_d = illegal_q;
    stop_d    = stop_q;

    case (state)
      ST_RESET: begin
        state_d = ST_FETCH;
        out_d   = fetch_strobes();
      end

      ST_FETCH: begin
        if (bus.mem_ready) begin
          // Opcode and flags are captured on this edge; later changes to
          // Z/C/opcode during EXEC cannot alter the registered strobes.
          state_d   = ST_EXEC;
          out_d     = dec_strobes;
          stop_d    = dec_stop | dec_illegal;
          illegal_d = illegal_q | dec_illegal;
        end else begin
          out_d = fetch_strobes();
        end
      end

      ST_EXEC: begin
        if (stop_q) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
          out_d   = fetch_strobes();
        end
      end

      ST_HALT: begin
        // The PC was not advanced, so resuming re-fetches the same word.
        if (bus.resume) begin
          state_d = ST_FETCH;
          out_d   = fetch_strobes();
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase

    halted_d = (state_d == ST_HALT);
  end

  // NOTE: the reset branch covers every flop here (state and outputs alike),
  // so asserting CL clears live strobes immediately without a clock edge.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk or posedge CL) begin
    if (CL) begin
      state     <= ST_RESET;
      out_q     <= STROBES_IDLE;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state     <= state_d;
      out_q     <= out_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      stop_q    <= stop_d;
    end
  end

  assign bus.LoadIR  = out_q.load_ir;
  assign bus.IncPC   = out_q.inc_pc;
  assign bus.SelPC   = out_q.sel_pc;
  assign bus.LoadPC  = out_q.load_pc;
  assign bus.LoadReg = out_q.load_reg;
  assign bus.LoadAcc = out_q.load_acc;
  assign bus.SelAcc  = out_q.sel_acc;
  assign bus.SelALU  = ALUW'(out_q.sel_alu);
  assign bus.halted  = halted_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_ctrl_fsm
// Self-checking bench for ctrl_fsm. Drives instruction sequences at the
// falling edge and compares every output cycle-by-cycle against a model
// built from the instruction table: (waits+1) fetch cycles, one execute
// cycle, then optional halt cycles. Uses a 5-bit opcode so values >= 16 are
// reachable, and a 6-bit SelALU so the zero upper bits are visible.
// -----------------------------------------------------------------------------
module tb_ctrl_fsm;

  localparam int OPW  = 5;
  localparam int ALUW = 6;

  // ALU code per legal opcode (0 where the opcode does not use the ALU).
  localparam logic [3:0] ALU_TAB [16] = '{
    4'h0, 4'h8, 4'hC, 4'h4, 4'h0, 4'h2, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h0, 4'h0, 4'h0
  };

  logic clk = 1'b0;
  logic CL;
  int   total = 0;
  int   bad   = 0;
  bit   ill_m;

  ctrl_fsm_if #(.OPW(OPW), .ALUW(ALUW)) bus ();

  ctrl_fsm #(.OPW(OPW), .ALUW(ALUW)) dut (
    .clk (clk),
    .CL  (CL),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] observed();
    return {bus.LoadIR, bus.IncPC, bus.SelPC, bus.LoadPC, bus.LoadReg,
            bus.LoadAcc, bus.SelAcc, bus.SelALU, bus.halted, bus.illegal};
  endfunction

  function automatic logic [15:0] pack(logic load_ir, logic inc, logic sel_pc,
                                       logic load_pc, logic load_reg,
                                       logic load_acc, logic [1:0] sel_acc,
                                       logic [5:0] sel_alu, logic halted,
                                       logic illegal);
    return {load_ir, inc, sel_pc, load_pc, load_reg, load_acc, sel_acc,
            sel_alu, halted, illegal};
  endfunction

  function automatic logic [15:0] exp_idle();
    return pack(0, 0, 0, 0, 0, 0, 2'b00, 6'd0, 0, ill_m);
  endfunction

  function automatic logic [15:0] exp_fetch();
    return pack(1, 0, 0, 0, 0, 0, 2'b00, 6'd0, 0, ill_m);
  endfunction

  function automatic logic [15:0] exp_halt();
    return pack(0, 0, 0, 0, 0, 0, 2'b00, 6'd0, 1, ill_m);
  endfunction

  function automatic bit halts(int op);
    return op >= 14;
  endfunction

  function automatic bit is_illegal(int op);
    return op == 14 || op >= 16;
  endfunction

  // Execute-cycle outputs straight from the instruction table.
  function automatic logic [15:0] exp_exec(int op, logic z, logic c);
    logic       jump, taken, ld_pc, inc, sel_pc, ld_acc, ld_reg;
    logic [1:0] sacc;
    logic [5:0] alu;
    jump   = (op >= 6 && op <= 10);
    taken  = (op == 6 || op == 7) ? z : (op == 9) ? !z : c;
    ld_pc  = jump && taken;
    inc    = (op <= 13) && !ld_pc;
    sel_pc = (op == 6 || op == 8);
    ld_acc = op inside {1, 2, 3, 4, 11, 12, 13};
    ld_reg = (op == 5);
    sacc   = (op == 4) ? 2'b10 : (op == 13) ? 2'b11 : 2'b00;
    alu    = (op < 16) ? 6'(ALU_TAB[op]) : 6'd0;
    return pack(0, inc, sel_pc, ld_pc, ld_reg, ld_acc, sacc, alu, 0, ill_m);
  endfunction

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_noise(input logic res);
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.opcode    = OPW'($urandom_range(0, 31));
    bus.Z         = 1'($urandom_range(0, 1));
    bus.C         = 1'($urandom_range(0, 1));
    bus.resume    = res;
  endtask

  // One instruction: fetch (with waits), execute, then halt_len checked HALT
  // cycles (resume pulsed in the last). abort asserts CL during execute.
  task automatic run_instr(input int op, input logic z, input logic c,
                           input int waits, input int halt_len, input bit abort);
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      check("fetch", observed(), exp_fetch());
      drive_noise(1'($urandom_range(0, 1)));
      bus.mem_ready = (w == waits);
      if (w == waits) begin
        bus.opcode = OPW'(op);
        bus.Z      = z;
        bus.C      = c;
      end
    end
    if (is_illegal(op)) ill_m = 1'b1;
    @(negedge clk);
    check($sformatf("exec_op%0d", op), observed(), exp_exec(op, z, c));
    drive_noise(1'($urandom_range(0, 1)));
    if (abort) begin
      #1 CL = 1'b1;
      ill_m = 1'b0;
      #1 check("abort_async", observed(), exp_idle());
      @(negedge clk);
      check("abort_hold", observed(), exp_idle());
      CL = 1'b0;
      #1 check("abort_release", observed(), exp_idle());
    end else if (halts(op)) begin
      for (int h = 0; h < halt_len; h++) begin
        @(negedge clk);
        check("halt", observed(), exp_halt());
        drive_noise(h == halt_len - 1);
      end
    end
  endtask

  initial begin
    CL            = 1'b1;
    bus.opcode    = '0;
    bus.Z         = 1'b0;
    bus.C         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.resume    = 1'b0;
    ill_m         = 1'b0;

    repeat (2) @(negedge clk);
    check("reset", observed(), exp_idle());
    CL = 1'b0;
    #1 check("reset_release", observed(), exp_idle());

    // Back-to-back ADD with memory always ready, then a 3-cycle stall.
    repeat (3) run_instr(1, 0, 0, 0, 0, 0);
    run_instr(1, 0, 0, 3, 0, 0);

    // Branches, taken and not taken.
    run_instr(6, 1, 0, 0, 0, 0);
    run_instr(6, 0, 0, 0, 0, 0);
    run_instr(9, 0, 0, 0, 0, 0);
    run_instr(9, 1, 0, 0, 0, 0);
    run_instr(8, 0, 1, 1, 0, 0);
    run_instr(10, 1, 0, 0, 0, 0);

    // STOP holds HALT for 10 cycles, then resume.
    run_instr(15, 0, 0, 0, 10, 0);
    // Illegal opcode: sticky flag survives resume and later instructions.
    run_instr(14, 0, 0, 1, 3, 0);
    run_instr(5, 0, 0, 0, 0, 0);
    run_instr(20, 0, 0, 0, 2, 0);
    run_instr(4, 0, 0, 0, 0, 0);

    // Reset in the middle of an LDI execute cycle.
    run_instr(13, 0, 0, 0, 0, 1);
    run_instr(2, 0, 0, 0, 0, 0);

    // Resume and reset together in HALT: reset wins.
    run_instr(15, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("halt_pre_cl", observed(), exp_halt());
    bus.resume = 1'b1;
    CL         = 1'b1;
    ill_m      = 1'b0;
    #1 check("cl_resume", observed(), exp_idle());
    @(negedge clk);
    check("cl_resume_hold", observed(), exp_idle());
    bus.resume = 1'b0;
    CL         = 1'b0;
    #1 check("cl_resume_release", observed(), exp_idle());

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      int r, op;
      r = $urandom_range(0, 99);
      if (r < 80)      op = $urandom_range(0, 13);
      else if (r < 88) op = 15;
      else if (r < 94) op = 14;
      else             op = $urandom_range(16, 31);
      run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(1, 4), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
